// File: rtl/jk_stage_driver.sv
// jk_stage_driver: serialises a word into J/K excitation for a JK storage stage,
// strobes it bit by bit, reads back q/q_bar and reports the readback word and error count.
`timescale 1ns/1ps
`default_nettype none

module jk_stage_driver #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             q_in,
  input  logic             q_bar_in,
  output logic             j,
  output logic             k,
  output logic             strobe,
  output logic             done_valid,
  output logic [WIDTH-1:0] done_data,
  output logic [CW-1:0]    err_count
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IW-1:0] LAST_IDX    = IW'(WIDTH - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic             tgt_q, tgt_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             strobe_q, strobe_d;
  logic             done_valid_q, done_valid_d;
  logic [WIDTH-1:0] done_data_q, done_data_d;
  logic [CW-1:0]    err_count_q, err_count_d;

  logic [IW-1:0]    nxt_idx;
  logic             bit_err;
  logic [CW-1:0]    acc_sum;
  logic             enter_drive;
  logic             next_tgt;

  assign nxt_idx = idx_q + 1'b1;
  // A wrong value and an illegal q == q_bar pair on the same bit count once.
  assign bit_err = (q_in != tgt_q) || (q_in == q_bar_in);
  assign acc_sum = acc_q + CW'(bit_err);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = S_DRIVE;
      S_DRIVE:  state_d = (SETTLE > 0) ? S_SETTLE : S_CHECK;
      S_SETTLE: if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
      S_CHECK:  state_d = (idx_q == LAST_IDX) ? S_REPORT : S_DRIVE;
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == S_IDLE);
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    rb_d         = rb_q;
    tgt_d        = tgt_q;
    acc_d        = acc_q;
    j_d          = 1'b0;
    k_d          = 1'b0;
    strobe_d     = 1'b0;
    done_valid_d = 1'b0;
    done_data_d  = done_data_q;
    err_count_d  = err_count_q;
    enter_drive  = 1'b0;
    next_tgt     = tgt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          word_d      = in_data;
          idx_d       = '0;
          acc_d       = '0;
          enter_drive = 1'b1;
          next_tgt    = in_data[0];
        end
      end
      S_DRIVE:  cnt_d = '0;
      S_SETTLE: cnt_d = cnt_q + 1'b1;
      S_CHECK: begin
        rb_d[idx_q] = q_in;
        acc_d       = acc_sum;
        if (idx_q == LAST_IDX) begin
          done_valid_d = 1'b1;
          done_data_d  = rb_d;
          err_count_d  = acc_sum;
        end else begin
          idx_d       = nxt_idx;
          enter_drive = 1'b1;
          next_tgt    = word_q[nxt_idx];
        end
      end
      default: ;
    endcase

    // Inverse JK characteristic: pulse only when the stage must change state.
    if (enter_drive) begin
      tgt_d = next_tgt;
      if (q_in != next_tgt) begin
        strobe_d = 1'b1;
        j_d      = next_tgt;
        k_d      = ~next_tgt;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q        <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      rb_q         <= '0;
      tgt_q        <= 1'b0;
      acc_q        <= '0;
      j_q          <= 1'b0;
      k_q          <= 1'b0;
      strobe_q     <= 1'b0;
      done_valid_q <= 1'b0;
      done_data_q  <= '0;
      err_count_q  <= '0;
    end else begin
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      rb_q         <= rb_d;
      tgt_q        <= tgt_d;
      acc_q        <= acc_d;
      j_q          <= j_d;
      k_q          <= k_d;
      strobe_q     <= strobe_d;
      done_valid_q <= done_valid_d;
      done_data_q  <= done_data_d;
      err_count_q  <= err_count_d;
    end
  end

  assign j          = j_q;
  assign k          = k_q;
  assign strobe     = strobe_q;
  assign done_valid = done_valid_q;
  assign done_data  = done_data_q;
  assign err_count  = err_count_q;

`ifndef SYNTHESIS
  a_no_double_strobe: assert property (@(posedge clock) disable iff (!reset_n) strobe_q |=> !strobe_q);
  a_no_jk_both:       assert property (@(posedge clock) disable iff (!reset_n) !(j_q && k_q));
  a_done_not_ready:   assert property (@(posedge clock) disable iff (!reset_n) !(done_valid_q && in_ready));
`endif

endmodule

`default_nettype wire

// File: tb/tb_jk_stage_driver.sv
// Scoreboard bench for jk_stage_driver: behavioural stage models drive q/q_bar,
// a word-level reference predicts readback, errors and J/K pulse positions.
`timescale 1ns/1ps
`default_nettype none

module tb_jk_stage_driver;

  localparam int W   = 8;
  localparam int S   = 2;
  localparam int PER = W * (S + 2) + 1;

  typedef struct {
    logic [7:0] data;
    int         err;
    logic [7:0] jm;
    logic [7:0] km;
    int         acc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, q_in, q_bar_in, j, k, strobe, done_valid;
  logic [7:0] done_data;
  logic [3:0] err_count;

  logic       in_valid2 = 1'b0;
  logic [3:0] in_data2 = '0;
  logic       in_ready2, q2_in, q2_bar_in, j2, k2, strobe2, done_valid2;
  logic [3:0] done_data2;
  logic [2:0] err_count2;

  int   mode = 0;          // 0 ideal, 1 q stuck at 0, 2 q_bar tied to q
  logic stage_q = 1'b0;
  logic stage2_q = 1'b0;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q_exp[$];
  exp_t q2_exp[$];
  int   last_acc = 0;
  int   ndone = 0;
  int   ndone2 = 0;
  int   viol = 0;
  bit   dut2_done = 1'b0;

  jk_stage_driver #(.WIDTH(W), .SETTLE(S)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .q_in(q_in), .q_bar_in(q_bar_in), .j(j), .k(k),
    .strobe(strobe), .done_valid(done_valid), .done_data(done_data), .err_count(err_count)
  );

  jk_stage_driver #(.WIDTH(4), .SETTLE(0)) dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .q_in(q2_in), .q_bar_in(q2_bar_in), .j(j2), .k(k2),
    .strobe(strobe2), .done_valid(done_valid2), .done_data(done_data2), .err_count(err_count2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural JK stages clocked by the strobe.
  always @(posedge clock) begin
    if (strobe) begin
      if (j) stage_q <= 1'b1;
      else if (k) stage_q <= 1'b0;
    end
    if (strobe2) begin
      if (j2) stage2_q <= 1'b1;
      else if (k2) stage2_q <= 1'b0;
    end
  end
  assign q_in      = (mode == 1) ? 1'b0 : stage_q;
  assign q_bar_in  = (mode == 2) ? q_in : ~q_in;
  assign q2_in     = stage2_q;
  assign q2_bar_in = ~stage2_q;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Word-level reference: walk the bits, deciding pulses from the observed q and
  // the stage's settled response.
  function automatic exp_t model(input logic [7:0] w, input int width, input logic q0,
                                 input int md, input int acc);
    exp_t e;
    logic q, qa, qb, t;
    e.data = '0; e.err = 0; e.jm = '0; e.km = '0; e.acc = acc;
    q = (md == 1) ? 1'b0 : q0;
    for (int i = 0; i < width; i++) begin
      t = w[i];
      if (q != t) begin
        if (t) e.jm[i] = 1'b1;
        else   e.km[i] = 1'b1;
      end
      qa = (md == 1) ? 1'b0 : t;
      qb = (md == 2) ? qa : ~qa;
      e.data[i] = qa;
      if (qa != t || qa == qb) e.err++;
      q = qa;
    end
    return e;
  endfunction

  exp_t       e_m;
  int         acc_m = 0;
  int         off_m;
  bit         busy_m = 1'b0;
  logic [7:0] jm_m = '0, km_m = '0;
  logic       prev_strobe = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      busy_m      = 1'b0;
      prev_strobe = 1'b0;
    end else begin
      if (strobe && prev_strobe) viol++;
      if (j && k) viol++;
      if ((j || k) && !strobe) viol++;
      if (done_valid && in_ready) viol++;
      if (strobe) begin
        off_m = cyc - acc_m - 1;
        if (busy_m && (off_m % (S + 2)) == 0 && (off_m / (S + 2)) < W) begin
          if (j) jm_m[off_m / (S + 2)] = 1'b1;
          if (k) km_m[off_m / (S + 2)] = 1'b1;
        end else begin
          viol++;
        end
      end
      if (done_valid) begin
        ndone++;
        if (q_exp.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e_m = q_exp.pop_front();
          check("done_data", int'(done_data), int'(e_m.data));
          check("err_count", int'(err_count), e_m.err);
          check("j_pulse_bits", int'(jm_m), int'(e_m.jm));
          check("k_pulse_bits", int'(km_m), int'(e_m.km));
          check("done_latency", cyc - e_m.acc, PER);
          check("protocol_violations", viol, 0);
        end
        busy_m = 1'b0;
      end
      if (in_valid && in_ready) begin
        busy_m = 1'b1;
        acc_m  = cyc;
        jm_m   = '0;
        km_m   = '0;
      end
      prev_strobe = strobe;
    end
  end

  exp_t e2_m;
  always @(negedge clock) begin
    if (reset_n && done_valid2) begin
      ndone2++;
      if (q2_exp.size() == 0) begin
        check("w4_unexpected_done", 1, 0);
      end else begin
        e2_m = q2_exp.pop_front();
        check("w4_done_data", int'(done_data2), int'(e2_m.data));
        check("w4_err_count", int'(err_count2), e2_m.err);
        check("w4_latency", cyc - e2_m.acc, 4 * 2 + 1);
      end
    end
  end

  task automatic send(input logic [7:0] w, input bit chained, input bit keep);
    bit got = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clock);
      if (in_ready) begin
        got = 1'b1;
        q_exp.push_back(model(w, W, stage_q, mode, cyc));
        if (chained) check("b2b_spacing", cyc - last_acc, W * (S + 2) + 2);
        last_acc = cyc;
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clock);
    #1;
    in_data = 8'($urandom);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400 && q_exp.size() > 0; n++) @(negedge clock);
    if (q_exp.size() > 0) check("done_timeout", int'(q_exp.size()), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobe"}, int'(strobe), 0);
    check({tag, "_j"}, int'(j), 0);
    check({tag, "_k"}, int'(k), 0);
    check({tag, "_done_valid"}, int'(done_valid), 0);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_done_data"}, int'(done_data), 0);
    check({tag, "_err_count"}, int'(err_count), 0);
  endtask

  initial begin
    int nw;
    int dn;
    logic [7:0] w;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    mode = 0;
    send(8'hFF, 1'b0, 1'b1);
    send(8'hFF, 1'b1, 1'b0);
    wait_idle();
    send(8'h00, 1'b0, 1'b1);
    send(8'hA5, 1'b1, 1'b0);
    wait_idle();
    mode = 1;
    send(8'h0F, 1'b0, 1'b0);
    wait_idle();
    mode = 0;
    send(8'h00, 1'b0, 1'b0);
    wait_idle();
    mode = 2;
    send(8'hFF, 1'b0, 1'b0);
    wait_idle();

    for (int b = 0; b < 8; b++) begin
      mode = $urandom_range(0, 2);
      nw   = $urandom_range(1, 3);
      for (int i = 0; i < nw; i++) send(8'($urandom), i > 0, i < nw - 1);
      wait_idle();
    end
    mode = 0;

    // Abort during the settle window of bit 3.
    send(8'h5A, 1'b0, 1'b0);
    while (cyc < last_acc + 14) @(negedge clock);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("settle_abort");
    q_exp.delete();
    @(negedge clock);
    @(negedge clock);
    #1 reset_n = 1'b1;
    dn = ndone;
    repeat (40) @(negedge clock);
    check("no_done_after_abort", ndone - dn, 0);
    check("ready_after_abort", int'(in_ready), 1);
    @(posedge clock);
    #1;
    send(8'h3C, 1'b0, 1'b0);
    wait_idle();

    // Abort while a strobe is high: it must fall without a clock edge.
    w = stage_q ? 8'h00 : 8'hFF;
    send(w, 1'b0, 1'b0);
    @(negedge clock);
    check("drive_strobe_high", int'(strobe), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_strobe_drop", int'(strobe), 0);
    check("async_j_drop", int'(j), 0);
    check("async_k_drop", int'(k), 0);
    q_exp.delete();
    @(negedge clock);
    @(negedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    send(8'($urandom), 1'b0, 1'b0);
    wait_idle();

    for (int n = 0; n < 200 && !dut2_done; n++) @(posedge clock);
    if (!dut2_done) check("w4_block_timeout", 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // WIDTH=4, SETTLE=0 instance: in_valid stays high with changing data while busy.
  initial begin
    bit got = 1'b0;
    @(posedge reset_n);
    @(posedge clock);
    #1;
    in_valid2 = 1'b1;
    in_data2  = 4'h9;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      if (in_ready2) begin
        got = 1'b1;
        q2_exp.push_back(model(8'h09, 4, stage2_q, 0, cyc));
      end
    end
    if (!got) check("w4_accept_timeout", 0, 1);
    for (int n = 0; n < 50 && ndone2 == 0; n++) begin
      @(posedge clock);
      #1;
      in_data2 = 4'($urandom);
    end
    in_valid2 = 1'b0;
    repeat (20) @(negedge clock);
    check("w4_single_done", ndone2, 1);
    check("w4_queue_empty", int'(q2_exp.size()), 0);
    dut2_done = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/jk_stage_driver.md
# jk_stage_driver

Sequential driver and readback checker for a JK storage stage. It accepts a WIDTH-bit word over a valid/ready handshake and converts each target bit into J/K excitation through the inverse of the JK characteristic. It strobes the stage, reads back q/q_bar, and reports the readback word with an error count. It sits upstream of the jk_trigger/d_trigger gate-level stages and serves as the write-side controller and self-checker for them.

## Interface
- WIDTH, 8: bits per word, driven LSB first; must be ≥1.
- SETTLE, 2: idle cycles between strobe and readback sample; must be ≥0.
- CW, $clog2(WIDTH+1): width of err_count (derived, not overridden).

- clock  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  word request valid.
- in_data  input  WIDTH  target word.
- in_ready  output  1  high only in IDLE; a word is accepted on a rising edge with in_valid && in_ready.
- q_in  input  1  stage q feedback.
- q_bar_in  input  1  stage q_bar feedback.
- j  output  1  registered J excitation.
- k  output  1  registered K excitation.
- strobe  output  1  registered enable pulse to the stage clock input.
- done_valid  output  1  one-cycle result pulse.
- done_data  output  WIDTH  readback word; held until the next done_valid.
- err_count  output  CW  bits failing check in the last word; held until the next done_valid.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK, REPORT. Bit index idx runs 0..WIDTH-1.
- IDLE: in_ready=1. On acceptance, in_data is latched, idx=0, the error accumulator is cleared, and the state goes to DRIVE.
- Entering DRIVE: q_in is captured as cur and target t = word[idx] is computed. The registered excitation is:
  - cur==t: j=0, k=0, strobe=0 (hold; no pulse).
  - cur!=t and t=1: j=1, k=0, strobe=1.
  - cur!=t and t=0: j=0, k=1, strobe=1.
  - j=k=1 is never driven.
- DRIVE lasts exactly one cycle. Leaving DRIVE clears j, k and strobe to 0. The next state is SETTLE if SETTLE>0, else CHECK.
- SETTLE: stays exactly SETTLE cycles with j=k=strobe=0, then goes to CHECK.
- CHECK: one cycle. At the edge leaving CHECK, q_in is stored into readback bit idx.
  - The error accumulator increments if q_in!=t, or if q_in==q_bar_in (invalid stage state). A bit counts as at most one error.
  - If idx==WIDTH-1 the next state is REPORT; otherwise idx increments and the next state is DRIVE.
- REPORT: one cycle. done_valid=1, and done_data/err_count are updated at entry. Next state is IDLE.
- in_valid is ignored outside IDLE. in_data changes while busy have no effect.
- err_count saturates naturally: max value is WIDTH, and CW bits hold it.

## Timing
- Reset (asynchronous, immediate on reset_n low): state=IDLE, in_ready=1, j=k=strobe=0, done_valid=0, done_data=0, err_count=0.
  - Inputs are ignored while reset_n is low.
  - Reset mid-word aborts the word with no done_valid. strobe drops immediately without waiting for an edge.
- Acceptance edge is N. Bit i DRIVE cycle is N+1+i*(SETTLE+2). Bit i CHECK cycle is that plus SETTLE+1.
- done_valid is high in cycle N+1+WIDTH*(SETTLE+2). With defaults that is N+33.
- in_ready returns high one cycle later (N+34). Minimum word-to-word spacing is WIDTH*(SETTLE+2)+2 cycles.
- Latency is data-independent: hold bits take the same time as toggled bits.
- strobe is never high for two consecutive cycles. j/k are nonzero only while strobe=1.
- done_valid and in_ready are never high in the same cycle.

## Test plan
- Ideal stage model (q follows J/K on strobe, q_bar=~q), initial q=0, in_data=8'hA5:
  - strobe pulses on bits 0, 1, 2, 3, 5, 6, 7 (j=1 on bits 0, 2, 5, 7; k=1 on bits 1, 3, 6).
  - No pulse on bit 4.
  - done_valid at N+33 with done_data=8'hA5, err_count=0.
- Same model, back-to-back words 8'hFF then 8'hFF:
  - First word: 8 pulses.
  - Second word: zero strobes and zero errors; in_ready at N+34 accepts it.
- Stage stuck at q=0, q_bar=1, in_data=8'h0F: done_data=8'h00, err_count=4.
- Stage forcing q=q_bar=1, in_data=8'hFF: err_count=8, with j=1 strobes still issued.
- reset_n pulsed low during SETTLE of bit 3:
  - strobe/j/k drop to 0 immediately and no done_valid occurs.
  - in_ready=1 after release; the next word 8'h3C completes normally with err_count=0.
- SETTLE=0, WIDTH=4, in_data=4'h9: done_valid at N+9, and in_valid held high while busy is ignored.
